// File: rtl/dm_access_ctrl.sv
//==============================================================================
// Module  : dm_access_ctrl
// Purpose : MEM-stage initiator for a single-port synchronous data memory.
//           Accepts load/store requests on a valid/ready handshake, issues the
//           memory cycle, and returns the word on a valid/ready response
//           channel. A hold register keeps the response stable under
//           back-pressure. Out-of-range word addresses are answered with an
//           error response and never reach memory.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dm_access_ctrl #(
   parameter int N = 7
) (
   input  logic          clka,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [31:0]   req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          ena,
   output logic          wea,
   output logic [N-1:0]  addra,
   output logic [31:0]   dina,
   input  logic [31:0]   douta
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t        r_state;
   logic [31:0]   r_hold;

   logic          w_accept;
   logic          w_in_range;
   logic          w_slot_free;

   // The response slot frees up this cycle when empty or being drained
   assign w_slot_free = (r_state == S_IDLE) | rsp_ready;

   // Handshake and memory command decode; memory is addressed in the accept cycle
   assign req_ready  = rstn & w_slot_free;
   assign w_accept   = req_valid & req_ready;
   assign w_in_range = (req_addr[31:N] == '0);
   assign ena        = w_accept & w_in_range;
   assign wea        = ena & req_we;
   assign addra      = req_addr[N-1:0];
   assign dina       = req_wdata;

   // State register plus capture of the read word when the consumer stalls
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_hold  <= '0;
      end else begin
         if (r_state == S_WAIT && !rsp_ready) begin
            // douta is only valid for this one cycle, so freeze it now
            r_hold  <= douta;
            r_state <= S_HOLD;
         end else if (w_slot_free) begin
            if (w_accept && w_in_range) begin
               r_state <= S_WAIT;
            end else if (w_accept) begin
               r_state <= S_ERR;
            end else begin
               r_state <= S_IDLE;
            end
         end
      end
   end

   // Response channel decode from the current state
   always_comb begin
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      case (r_state)
         S_WAIT: begin
            rsp_valid = 1'b1;
            rsp_rdata = douta;
         end
         S_HOLD: begin
            rsp_valid = 1'b1;
            rsp_rdata = r_hold;
         end
         S_ERR: begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
         end
         default: begin
            rsp_valid = 1'b0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
//==============================================================================
// Module  : tb_dm_access_ctrl
// Purpose : Directed, table-driven bench for dm_access_ctrl with a behavioural
//           single-port synchronous memory attached.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dm_access_ctrl;

   localparam int N = 7;

   logic          clka;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          ena;
   logic          wea;
   logic [N-1:0]  addra;
   logic [31:0]   dina;
   logic [31:0]   douta;

   int errors;
   int checks;

   dm_access_ctrl #(.N(N)) dut (
      .clka      (clka),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ena       (ena),
      .wea       (wea),
      .addra     (addra),
      .dina      (dina),
      .douta     (douta)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   // Behavioural RAM: write-first on stores; output scrambled when not enabled
   logic [31:0] mem [0:(2**N)-1];
   logic [31:0] scramble;
   always @(posedge clka) begin
      scramble <= scramble + 32'h0101_0101;
      if (ena) begin
         if (wea) begin
            mem[addra] <= dina;
            douta      <= dina;
         end else begin
            douta      <= mem[addra];
         end
      end else begin
         douta <= 32'hBADB_AD00 ^ scramble;
      end
   end

   typedef struct {
      string       name;
      logic        valid;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        rdy;
      logic        e_ena;
      logic        e_wea;
      logic        e_rrdy;
      logic        e_rv;
      logic [31:0] e_rd;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input string name, input logic valid, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic rdy, input logic e_ena, input logic e_wea,
                               input logic e_rrdy, input logic e_rv,
                               input logic [31:0] e_rd, input logic e_err);
      vec_t v;
      v.name = name; v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
      v.rdy = rdy; v.e_ena = e_ena; v.e_wea = e_wea; v.e_rrdy = e_rrdy;
      v.e_rv = e_rv; v.e_rd = e_rd; v.e_err = e_err;
      return v;
   endfunction

   task automatic drive(input logic valid, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic rdy);
      req_valid = valid;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      rsp_ready = rdy;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      scramble = 32'h0;
      rstn     = 1'b0;
      drive(1'b1, 1'b1, 32'd5, 32'h1234_5678, 1'b1);

      //            name        v  we addr        wdata         rdy ena wea rrdy rv rdata         err
      // store / load round trip
      tbl.push_back(mk("st5",   1, 1, 32'd5,     32'hDEADBEEF, 1, 1, 1, 1, 0, 32'h0,        0));
      tbl.push_back(mk("ld5",   1, 0, 32'd5,     32'h0,        1, 1, 0, 1, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk("ld5r",  0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk("idle0", 0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 0, 32'h0,        0));
      // back-to-back preload stores
      tbl.push_back(mk("st1",   1, 1, 32'd1,     32'h11,       1, 1, 1, 1, 0, 32'h0,        0));
      tbl.push_back(mk("st2",   1, 1, 32'd2,     32'h22,       1, 1, 1, 1, 1, 32'h11,       0));
      tbl.push_back(mk("st3",   1, 1, 32'd3,     32'h33,       1, 1, 1, 1, 1, 32'h22,       0));
      tbl.push_back(mk("st0",   1, 1, 32'd0,     32'hA5A5A5A5, 1, 1, 1, 1, 1, 32'h33,       0));
      tbl.push_back(mk("st0r",  0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 1, 32'hA5A5A5A5, 0));
      // back-to-back loads
      tbl.push_back(mk("ld1",   1, 0, 32'd1,     32'h0,        1, 1, 0, 1, 0, 32'h0,        0));
      tbl.push_back(mk("ld2",   1, 0, 32'd2,     32'h0,        1, 1, 0, 1, 1, 32'h11,       0));
      tbl.push_back(mk("ld3",   1, 0, 32'd3,     32'h0,        1, 1, 0, 1, 1, 32'h22,       0));
      tbl.push_back(mk("ld3r",  0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 1, 32'h33,       0));
      tbl.push_back(mk("idle1", 0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 0, 32'h0,        0));
      // out of range: load 0x80, store 0x100 (must not write), then read addr 0
      tbl.push_back(mk("ld80",  1, 0, 32'h80,    32'h0,        1, 0, 0, 1, 0, 32'h0,        0));
      tbl.push_back(mk("st100", 1, 1, 32'h100,   32'hFFFFFFFF, 1, 0, 0, 1, 1, 32'h0,        1));
      tbl.push_back(mk("ld0",   1, 0, 32'd0,     32'h0,        1, 1, 0, 1, 1, 32'h0,        1));
      tbl.push_back(mk("ld0r",  0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 1, 32'hA5A5A5A5, 0));
      tbl.push_back(mk("idle2", 0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 0, 32'h0,        0));
      // back-pressure: load 5 stalled for 3 cycles while load 1 waits
      tbl.push_back(mk("bp0",   1, 0, 32'd5,     32'h0,        0, 1, 0, 1, 0, 32'h0,        0));
      tbl.push_back(mk("bp1",   1, 0, 32'd1,     32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk("bp2",   1, 0, 32'd1,     32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk("bp3",   1, 0, 32'd1,     32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk("bp4",   1, 0, 32'd1,     32'h0,        1, 1, 0, 1, 1, 32'hDEADBEEF, 0));
      tbl.push_back(mk("bp5",   0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 1, 32'h11,       0));
      tbl.push_back(mk("idle3", 0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 0, 32'h0,        0));
      // error response held under back-pressure
      tbl.push_back(mk("eb0",   1, 0, 32'h80,    32'h0,        0, 0, 0, 1, 0, 32'h0,        0));
      tbl.push_back(mk("eb1",   1, 1, 32'd7,     32'h77,       0, 0, 0, 0, 1, 32'h0,        1));
      tbl.push_back(mk("eb2",   0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 1, 32'h0,        1));
      tbl.push_back(mk("idle4", 0, 0, 32'd0,     32'h0,        1, 0, 0, 1, 0, 32'h0,        0));

      // Reset with a request pending: nothing may reach memory
      #2;
      chk("rst_ena",       {31'b0, ena},       32'd0);
      chk("rst_wea",       {31'b0, wea},       32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
      chk("rst_rsp_rdata", rsp_rdata,          32'd0);
      @(negedge clka);
      @(negedge clka);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      rstn = 1'b1;
      #2;
      chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clka);
         drive(tbl[i].valid, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdy);
         #2;
         chk({tbl[i].name, "_ena"},       {31'b0, ena},       {31'b0, tbl[i].e_ena});
         chk({tbl[i].name, "_wea"},       {31'b0, wea},       {31'b0, tbl[i].e_wea});
         chk({tbl[i].name, "_req_ready"}, {31'b0, req_ready}, {31'b0, tbl[i].e_rrdy});
         chk({tbl[i].name, "_rsp_valid"}, {31'b0, rsp_valid}, {31'b0, tbl[i].e_rv});
         chk({tbl[i].name, "_rsp_rdata"}, rsp_rdata,          tbl[i].e_rd);
         chk({tbl[i].name, "_rsp_err"},   {31'b0, rsp_err},   {31'b0, tbl[i].e_err});
         if (tbl[i].e_ena) begin
            chk({tbl[i].name, "_addra"}, {25'b0, addra}, {25'b0, tbl[i].addr[N-1:0]});
            chk({tbl[i].name, "_dina"},  dina,           tbl[i].wdata);
         end
      end

      // Reset while holding a stalled response
      @(negedge clka);
      drive(1'b1, 1'b0, 32'd2, 32'd0, 1'b0);           // accept load 2
      @(negedge clka);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);           // WAIT, stalled
      @(negedge clka);                                  // now in HOLD
      #2;
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata,          32'h22);
      drive(1'b1, 1'b0, 32'd3, 32'd0, 1'b1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("mid_rst_ena",       {31'b0, ena},       32'd0);
      chk("mid_rst_rsp_rdata", rsp_rdata,          32'd0);
      @(negedge clka);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      rstn = 1'b1;
      #2;
      chk("rel_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clka);
      drive(1'b1, 1'b0, 32'd3, 32'd0, 1'b1);           // fresh load 3
      #2;
      chk("fresh_rsp_valid_pre", {31'b0, rsp_valid}, 32'd0);
      chk("fresh_ena",           {31'b0, ena},       32'd1);
      @(negedge clka);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      #2;
      chk("fresh_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("fresh_rsp_rdata", rsp_rdata,          32'h33);
      @(negedge clka);
      #2;
      chk("fresh_done_valid", {31'b0, rsp_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
